// File: rtl/noc_packet_receiver_pkg.sv
// noc_packet_receiver_pkg: shared NoC widths and receiver FSM state type
package noc_packet_receiver_pkg;
  localparam int NOC_DATA_WIDTH = 64;
  localparam int NOC_ID_X_WIDTH = 4;
  localparam int NOC_ID_Y_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, BODY, DROP} rx_state_e;
endpackage

// File: rtl/noc_rx_fifo.sv
// noc_rx_fifo: synchronous first-word-fall-through FIFO with count/full/empty
module noc_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_count = r_count;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_data = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/noc_packet_receiver.sv
// noc_packet_receiver: header/data/tail flit sink that filters by dest and streams payload beats
module noc_packet_receiver
  import noc_packet_receiver_pkg::*;
#(
  parameter int FLIT_W  = NOC_DATA_WIDTH,
  parameter int ID_X_W  = NOC_ID_X_WIDTH,
  parameter int ID_Y_W  = NOC_ID_Y_WIDTH,
  parameter int HMARK_W = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0,
  parameter int DEPTH   = 4
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [FLIT_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_data,
  output logic              out_last,
  output logic [ID_X_W-1:0] out_src_x,
  output logic [ID_Y_W-1:0] out_src_y,
  output logic [15:0]       pkt_count,
  output logic [7:0]        err_count,
  output logic              err_pulse
);
  localparam int EW = ID_X_W + ID_Y_W + 1 + FLIT_W;
  localparam int SXH = FLIT_W - HMARK_W - 1;
  localparam int CW = $clog2(DEPTH) + 1;
  rx_state_e r_state, w_nxt;
  logic [FLIT_W-1:0] r_hold;
  logic r_hold_vld, r_err_pulse;
  logic [ID_X_W-1:0] r_src_x;
  logic [ID_Y_W-1:0] r_src_y;
  logic [15:0] r_pkt;
  logic [7:0] r_err;
  logic w_acc, w_match, w_push, w_last, w_err, w_pkt, w_hold_ld, w_hold_clr, w_src_ld;
  logic w_full, w_empty;
  logic [CW-1:0] w_count;
  logic [EW-1:0] w_rd;
  assign w_acc = receive_valid && receive_ready;
  assign w_match = receive_flit[SXH-ID_X_W-ID_Y_W -: ID_X_W] == ID_X_W'(MY_X) &&
                   receive_flit[SXH-2*ID_X_W-ID_Y_W -: ID_Y_W] == ID_Y_W'(MY_Y);
  assign receive_ready = w_count < CW'(DEPTH);
  assign out_valid = !w_empty;
  assign {out_src_x, out_src_y, out_last, out_data} = w_rd;
  assign pkt_count = r_pkt;
  assign err_count = r_err;
  assign err_pulse = r_err_pulse;
  always_comb begin
    w_nxt = r_state;
    w_push = 1'b0;
    w_last = 1'b0;
    w_err = 1'b0;
    w_pkt = 1'b0;
    w_hold_ld = 1'b0;
    w_hold_clr = 1'b0;
    w_src_ld = 1'b0;
    if (w_acc) begin
      if (receive_is_header) begin
        w_err = r_state != IDLE || !w_match;
        w_push = r_state == BODY && r_hold_vld;
        w_last = 1'b1;
        w_hold_clr = 1'b1;
        w_src_ld = w_match;
        w_pkt = w_match && receive_is_tail;
        w_nxt = receive_is_tail ? IDLE : w_match ? BODY : DROP;
      end else if (r_state == IDLE) begin
        w_err = 1'b1;
      end else if (r_state == BODY) begin
        w_push = r_hold_vld;
        w_last = receive_is_tail;
        w_hold_ld = !receive_is_tail;
        w_hold_clr = receive_is_tail;
        w_pkt = receive_is_tail;
        w_nxt = receive_is_tail ? IDLE : BODY;
      end else begin
        w_nxt = receive_is_tail ? IDLE : DROP;
      end
    end
  end
  // The held flit is pushed with the current source before a new header overwrites it
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      r_state <= IDLE;
      r_hold <= '0;
      r_hold_vld <= 1'b0;
      r_src_x <= '0;
      r_src_y <= '0;
      r_pkt <= '0;
      r_err <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_hold_ld) begin
        r_hold <= receive_flit;
        r_hold_vld <= 1'b1;
      end else if (w_hold_clr) begin
        r_hold_vld <= 1'b0;
      end
      if (w_src_ld) begin
        r_src_x <= receive_flit[SXH -: ID_X_W];
        r_src_y <= receive_flit[SXH-ID_X_W -: ID_Y_W];
      end
      if (w_pkt) r_pkt <= r_pkt + 16'd1;
      if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
      r_err_pulse <= w_err;
    end
  end
  noc_rx_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk(noc_clk),
    .i_rst(noc_rst),
    .i_push(w_push && !w_full),
    .i_data({r_src_x, r_src_y, w_last, r_hold}),
    .i_pop(out_ready),
    .o_data(w_rd),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_noc_packet_receiver.sv
// tb_noc_packet_receiver: table-driven flit vectors with a beat scoreboard plus corner sequences
module tb_noc_packet_receiver;
  logic clk = 1'b0, rst = 1'b1;
  logic rv = 1'b0, rh = 1'b0, rt = 1'b0, ord = 1'b1;
  logic [63:0] rf = '0;
  logic rr, ov, ol, ep;
  logic [63:0] od;
  logic [3:0] osx, osy;
  logic [15:0] pc;
  logic [7:0] ec;
  int checks = 0, errors = 0;

  typedef struct {logic [3:0] x, y; logic l; logic [63:0] d;} beat_t;
  typedef struct {
    logic h, t; logic [63:0] f;
    logic eb, el; logic [3:0] ex, ey;
    logic [15:0] pkt; logic [7:0] err; logic ep;
  } vec_t;
  beat_t sbq[$];
  vec_t vecs[$];

  noc_packet_receiver dut (
    .noc_clk(clk), .noc_rst(rst),
    .receive_valid(rv), .receive_ready(rr), .receive_flit(rf),
    .receive_is_header(rh), .receive_is_tail(rt),
    .out_valid(ov), .out_ready(ord), .out_data(od), .out_last(ol),
    .out_src_x(osx), .out_src_y(osy),
    .pkt_count(pc), .err_count(ec), .err_pulse(ep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [3:0] sx, sy, dx, dy);
    return {4'hA, sx, sy, dx, dy, 44'h0};
  endfunction

  function automatic vec_t v(input logic h, t, input logic [63:0] f, input logic eb, el,
                             input logic [3:0] ex, ey, input logic [15:0] pkt,
                             input logic [7:0] err, input logic e);
    vec_t r;
    r.h = h; r.t = t; r.f = f; r.eb = eb; r.el = el; r.ex = ex; r.ey = ey;
    r.pkt = pkt; r.err = err; r.ep = e;
    return r;
  endfunction

  task automatic expect_beat(input logic [3:0] x, y, input logic l, input logic [63:0] d);
    beat_t b;
    b.x = x; b.y = y; b.l = l; b.d = d;
    sbq.push_back(b);
  endtask

  task automatic send(input logic h, t, input logic [63:0] f);
    int n = 0;
    rv = 1'b1; rh = h; rt = t; rf = f;
    while (!rr && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    rv = 1'b0; rh = 1'b0; rt = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ov && ord) begin
      if (sbq.size() == 0) begin
        chk("unexpected_beat", od, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        beat_t b;
        b = sbq.pop_front();
        chk("beat_data", od, b.d);
        chk("beat_last", 64'(ol), 64'(b.l));
        chk("beat_src", 64'({osx, osy}), 64'({b.x, b.y}));
      end
    end
  end

  initial begin
    vecs.push_back(v(1, 0, hdr(1, 2, 0, 0), 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, '1,              1, 1, 1, 2, 0, 0, 0));
    vecs.push_back(v(0, 1, 64'h0,           0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, hdr(3, 4, 0, 0), 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 64'hA,           1, 0, 3, 4, 1, 0, 0));
    vecs.push_back(v(0, 0, 64'hB,           1, 0, 3, 4, 1, 0, 0));
    vecs.push_back(v(0, 0, 64'hC,           1, 1, 3, 4, 1, 0, 0));
    vecs.push_back(v(0, 1, 64'h0,           0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(v(1, 0, hdr(5, 5, 3, 3), 0, 0, 0, 0, 2, 1, 1));
    vecs.push_back(v(0, 0, 64'h1,           0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(v(0, 0, 64'h2,           0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(v(0, 1, 64'h3,           0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(v(1, 0, hdr(6, 7, 0, 0), 0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(v(0, 0, 64'h11,          1, 1, 6, 7, 2, 1, 0));
    vecs.push_back(v(0, 1, 64'h0,           0, 0, 0, 0, 3, 1, 0));
    vecs.push_back(v(0, 0, 64'h99,          0, 0, 0, 0, 3, 2, 1));
    vecs.push_back(v(1, 0, hdr(2, 3, 0, 0), 0, 0, 0, 0, 3, 2, 0));
    vecs.push_back(v(0, 0, 64'h5,           1, 1, 2, 3, 3, 2, 0));
    vecs.push_back(v(1, 0, hdr(4, 1, 0, 0), 0, 0, 0, 0, 3, 3, 1));
    vecs.push_back(v(0, 0, 64'h77,          1, 1, 4, 1, 3, 3, 0));
    vecs.push_back(v(0, 1, 64'h0,           0, 0, 0, 0, 4, 3, 0));
    vecs.push_back(v(1, 1, hdr(8, 9, 0, 0), 0, 0, 0, 0, 5, 3, 0));
    vecs.push_back(v(1, 0, hdr(1, 1, 0, 0), 0, 0, 0, 0, 5, 3, 0));
    vecs.push_back(v(0, 1, 64'h0,           0, 0, 0, 0, 6, 3, 0));

    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 64'(rr), 64'd1);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_out", {od[59:0], ol, 3'b0} | 64'({osx, osy}), 64'd0);
    chk("rst_counts", 64'({pc, ec, ep}), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].eb) expect_beat(vecs[i].ex, vecs[i].ey, vecs[i].el, vecs[i].f);
      send(vecs[i].h, vecs[i].t, vecs[i].f);
      chk($sformatf("v%0d_pkt", i), 64'(pc), 64'(vecs[i].pkt));
      chk($sformatf("v%0d_err", i), 64'(ec), 64'(vecs[i].err));
      chk($sformatf("v%0d_pulse", i), 64'(ep), 64'(vecs[i].ep));
    end
    repeat (3) @(posedge clk);
    #1 chk("pulse_idle", 64'(ep), 64'd0);

    ord = 1'b0;
    for (int i = 0; i < 6; i++) expect_beat(4'h7, 4'h3, i == 5, 64'h600 + 64'(i));
    fork
      begin
        send(1, 0, hdr(7, 3, 0, 0));
        for (int i = 0; i < 6; i++) send(0, 0, 64'h600 + 64'(i));
        send(0, 1, 64'h0);
      end
      begin
        repeat (15) @(posedge clk);
        #1;
        chk("bp_ready_low", 64'(rr), 64'd0);
        chk("bp_valid", 64'(ov), 64'd1);
        chk("bp_pkt_hold", 64'(pc), 64'd6);
        ord = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("bp_pkt", 64'(pc), 64'd7);
    chk("bp_drained", 64'(sbq.size()), 64'd0);

    ord = 1'b0;
    send(1, 0, hdr(2, 2, 0, 0));
    send(0, 0, 64'h100);
    send(0, 0, 64'h101);
    chk("pre_rst_valid", 64'(ov), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(ov), 64'd0);
    chk("mid_rst_out", od | 64'({ol, osx, osy}), 64'd0);
    chk("mid_rst_counts", 64'({pc, ec, ep}), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(rr), 64'd1);
    ord = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    expect_beat(4'h3, 4'h1, 1'b1, 64'h42);
    send(1, 0, hdr(3, 1, 0, 0));
    send(0, 0, 64'h42);
    send(0, 1, 64'h0);
    chk("post_rst_pkt", 64'(pc), 64'd1);
    chk("post_rst_err", 64'(ec), 64'd0);

    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(posedge clk);
    #1 chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_packet_receiver.md
Name: noc_packet_receiver

Overview:
- Receive-side endpoint for the NoC local port. It is the consuming end of the header/data/tail flit protocol that test nodes and network interfaces transmit.
- Accepts flits under valid/ready, parses the header for source and destination IDs, and filters misrouted packets.
- Strips header and tail flits and emits payload flits as a beat stream with a last marker and source tag.
- Maintains packet and error counters for bench checking.

Parameters:
- FLIT_W, 64, flit width; equals `Noc_Data_Width.
- ID_X_W, 4, X ID width; equals `Noc_ID_X_Width.
- ID_Y_W, 4, Y ID width; equals `Noc_ID_Y_Width.
- HMARK_W, 4, width of the header-marker field at the flit MSBs.
- MY_X, 0, this node's X ID.
- MY_Y, 0, this node's Y ID.
- DEPTH, 4, payload FIFO depth (power of 2, ≥2).

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  reset; asynchronous, active-high.
- receive_valid  in  1  flit valid.
- receive_ready  out  1  flit accept.
- receive_flit  in  FLIT_W  flit.
- receive_is_header  in  1  header flag.
- receive_is_tail  in  1  tail flag.
- out_valid  out  1  payload beat valid.
- out_ready  in  1  payload beat accept.
- out_data  out  FLIT_W  payload flit.
- out_last  out  1  final payload beat of packet.
- out_src_x  out  ID_X_W  source X of packet.
- out_src_y  out  ID_Y_W  source Y of packet.
- pkt_count  out  16  good packets completed; wraps.
- err_count  out  8  protocol/route errors; saturates at 255.
- err_pulse  out  1  one-cycle strobe per error.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - receive_ready=1; out_valid=0; out_data=0; out_last=0; out_src_x/y=0.
  - pkt_count=0; err_count=0; err_pulse=0.
  - FSM=IDLE; FIFO empty; hold register empty.
  - Reset mid-packet discards the partial packet; nothing is emitted for it.
- Accept: a flit is accepted when receive_valid && receive_ready.
  - receive_ready = (fifo_count < DEPTH). It is registered-state-derived only; there is no combinational path from out_ready. A same-cycle pop does not raise ready.
- Header fields:
  - src X = flit[FLIT_W-HMARK_W-1 -: ID_X_W], then src Y, dest X, dest Y contiguous below it.
  - Together these match `Noc_Point_H/`Noc_Source_Point.
- Hold register: one data flit is held until the next accepted flit shows whether it was the last payload beat. Each accepted flit causes at most one FIFO push, so ready never overruns.
- FIFO: entries are {src_x, src_y, last, data}, first-word-fall-through. A push at edge t makes out_valid=1 in the following cycle. A pop occurs on out_valid && out_ready. Simultaneous push/pop keeps the count.
- FSM states: IDLE, BODY, DROP.
- IDLE:
  - Header with dest == (MY_X,MY_Y): latch src, go to BODY.
  - Header with dest mismatch: error, go to DROP.
  - Header with is_tail also set: single-flit packet; pkt_count+1, no output, stay in IDLE.
  - Non-header flit: dropped, error, stay in IDLE.
- BODY:
  - Data flit: push any held flit with last=0, then hold the new flit.
  - Tail flit: push held flit with last=1; pkt_count+1; go to IDLE. A zero-payload packet (hold empty) still counts with no output.
  - Header flit: error; push held flit with last=1; process the new header as in IDLE (BODY, or DROP on mismatch).
- DROP: consume flits without output; tail → IDLE. A header in DROP is an error and is processed as in IDLE.
- Errors: each error asserts err_pulse for exactly one cycle and increments err_count, saturating. Simultaneous errors cannot occur (one flit per cycle).

Decomposition:
- Widths and field positions come from the shared Noc_parameters macros (`Noc_Data_Width, `Noc_ID_*_Width, `Noc_Point_H, `Noc_Source_Point). No new package content.
- One sub-module: noc_rx_fifo, a synchronous FWFT FIFO with parameters WIDTH and DEPTH, exposing count, full, and empty.

Test Plan:
- Reset asserted mid-run → all outputs at reset values; ready=1 the cycle after release.
- Header src(1,2), dest(0,0), then data all-ones, then tail → one beat: data=all-ones, last=1, src=(1,2); pkt_count=1; err_count=0.
- Header, data 0xA, 0xB, 0xC, tail → beats A, B, C in order with last only on C; pkt_count=1.
- out_ready=0 with a 6-data packet streamed → receive_ready drops once 4 entries are pushed; with out_ready=1 all 6 beats emerge in order, none lost or duplicated.
- Header dest(3,3), 2 data, tail → no output; err_pulse once; err_count=1. A following good packet passes normally.
- Data flit in IDLE → dropped, err_count+1. Header in mid-BODY after data 0x5 → beat 0x5 emitted with last=1, err_count+1, and the new packet completes with pkt_count incremented.
